// File: rtl/game_pkg.sv
// game_pkg: game state encodings, state/score types and saturating score increment shared with the display path
package game_pkg;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_OVER      = 3'd4
  } state_t;
  typedef logic [3:0] score_t;
  function automatic score_t sat_inc(input score_t s);
    return (s == 4'hf) ? s : s + 4'd1;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler pulsing tick for one cycle every TICK_DIV clks; ports clk, rst (sync active-low), clr (restart count) -> tick
module tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt_q;
  assign tick = cnt_q == W'(TICK_DIV - 1);
  always_ff @(posedge clk)
    cnt_q <= (!rst || clr || tick) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game FSM, scores and countdown digit; ports clk, rst (sync active-low), start/p0_hit/p1_hit pulses -> state, score0, score1, cnt0, play_en, winner
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int COUNT_FROM = 3,
  parameter int POINT_HOLD = 2,
  parameter int WIN_SCORE  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       p0_hit,
  input  logic       p1_hit,
  output logic [2:0] state,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [3:0] cnt0,
  output logic       play_en,
  output logic       winner
);
  localparam score_t CF = score_t'(COUNT_FROM);
  localparam score_t PH = score_t'(POINT_HOLD);
  localparam score_t WS = score_t'(WIN_SCORE);
  state_t state_q, state_d;
  score_t score0_q, score0_d, score1_q, score1_d, cnt0_q, cnt0_d;
  logic winner_q, winner_d, play_en_q, tick;
  // restarting the prescaler on every transition makes each dwell an exact multiple of TICK_DIV
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_d != state_q),
    .tick (tick)
  );
  always_comb begin
    state_d  = state_q;
    score0_d = score0_q;
    score1_d = score1_q;
    cnt0_d   = cnt0_q;
    winner_d = winner_q;
    case (state_q)
      ST_IDLE: begin
        score0_d = '0;
        score1_d = '0;
        cnt0_d   = start ? CF : '0;
        state_d  = start ? ST_COUNTDOWN : ST_IDLE;
      end
      ST_COUNTDOWN: begin
        cnt0_d  = tick ? cnt0_q - 4'd1 : cnt0_q;
        state_d = (tick && cnt0_q == 4'd1) ? ST_PLAY : ST_COUNTDOWN;
      end
      ST_PLAY: if (p0_hit != p1_hit) begin
        state_d  = ST_POINT;
        cnt0_d   = PH;
        score0_d = p0_hit ? sat_inc(score0_q) : score0_q;
        score1_d = p1_hit ? sat_inc(score1_q) : score1_q;
      end
      ST_POINT: if (tick) begin
        if (cnt0_q != 4'd1) cnt0_d = cnt0_q - 4'd1;
        else if (score0_q == WS || score1_q == WS) begin
          state_d  = ST_OVER;
          cnt0_d   = '0;
          winner_d = score0_q != WS;
        end else begin
          state_d = ST_COUNTDOWN;
          cnt0_d  = CF;
        end
      end
      ST_OVER: begin
        cnt0_d = start ? CF : '0;
        if (start) begin
          state_d  = ST_COUNTDOWN;
          score0_d = '0;
          score1_d = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        score0_d = '0;
        score1_d = '0;
        cnt0_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      score0_q  <= '0;
      score1_q  <= '0;
      cnt0_q    <= '0;
      winner_q  <= 1'b0;
      play_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      score0_q  <= score0_d;
      score1_q  <= score1_d;
      cnt0_q    <= cnt0_d;
      winner_q  <= winner_d;
      play_en_q <= state_d == ST_PLAY;
    end
  end
  assign state   = state_q;
  assign score0  = score0_q;
  assign score1  = score1_q;
  assign cnt0    = cnt0_q;
  assign play_en = play_en_q;
  assign winner  = winner_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed scenarios plus randomized games checked against a timeline model of game_flow_ctrl
module tb_game_flow_ctrl;
  localparam int TD = 4, CF = 3, PH = 2, WS = 2;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, p0_hit = 1'b0, p1_hit = 1'b0;
  logic [2:0] state;
  logic [3:0] score0, score1, cnt0;
  logic play_en, winner;
  logic [16:0] obs;
  int pass_cnt = 0, total = 0;
  always #5 clk = ~clk;
  game_flow_ctrl #(.TICK_DIV(TD), .COUNT_FROM(CF), .POINT_HOLD(PH), .WIN_SCORE(WS)) dut (
    .clk(clk), .rst(rst), .start(start), .p0_hit(p0_hit), .p1_hit(p1_hit),
    .state(state), .score0(score0), .score1(score1), .cnt0(cnt0),
    .play_en(play_en), .winner(winner)
  );
  assign obs = {state, score0, score1, cnt0, play_en, winner};
  function automatic logic [16:0] ex(input int st, s0, s1, c, pe, w);
    return {3'(st), 4'(s0), 4'(s1), 4'(c), 1'(pe), 1'(w)};
  endfunction
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse(input bit s, input bit h0, input bit h1);
    start = s; p0_hit = h0; p1_hit = h1;
    cyc(1);
    start = 0; p0_hit = 0; p1_hit = 0;
  endtask
  task automatic noise(input int n, input bit allow_start);
    repeat (n) begin
      start  = allow_start && ($urandom_range(0, 3) == 0);
      p0_hit = $urandom_range(0, 2) == 0;
      p1_hit = $urandom_range(0, 2) == 0;
      cyc(1);
    end
    start = 0; p0_hit = 0; p1_hit = 0;
  endtask
  task automatic test_reset;
    rst = 0; start = 1; p0_hit = 1;
    cyc(3);
    total++; if (obs !== ex(0,0,0,0,0,0)) $display("FAIL reset_values got %h want %h", obs, ex(0,0,0,0,0,0)); else pass_cnt++;
    rst = 1; start = 0; p0_hit = 0;
  endtask
  task automatic test_start;
    cyc(5);
    pulse(0, 1, 1);
    total++; if (obs !== ex(0,0,0,0,0,0)) $display("FAIL idle_hits got %h want %h", obs, ex(0,0,0,0,0,0)); else pass_cnt++;
    pulse(1, 0, 0);
    total++; if (obs !== ex(1,0,0,3,0,0)) $display("FAIL start_entry got %h want %h", obs, ex(1,0,0,3,0,0)); else pass_cnt++;
    cyc(3);
    total++; if (obs !== ex(1,0,0,3,0,0)) $display("FAIL cd_before_tick got %h want %h", obs, ex(1,0,0,3,0,0)); else pass_cnt++;
    pulse(1, 0, 0);
    total++; if (obs !== ex(1,0,0,2,0,0)) $display("FAIL cd_tick1_with_start got %h want %h", obs, ex(1,0,0,2,0,0)); else pass_cnt++;
    cyc(3);
    total++; if (obs !== ex(1,0,0,2,0,0)) $display("FAIL cd_hold2 got %h want %h", obs, ex(1,0,0,2,0,0)); else pass_cnt++;
    cyc(1);
    total++; if (obs !== ex(1,0,0,1,0,0)) $display("FAIL cd_tick2 got %h want %h", obs, ex(1,0,0,1,0,0)); else pass_cnt++;
    cyc(3);
    total++; if (obs !== ex(1,0,0,1,0,0)) $display("FAIL cd_hold1 got %h want %h", obs, ex(1,0,0,1,0,0)); else pass_cnt++;
    cyc(1);
    total++; if (obs !== ex(2,0,0,0,1,0)) $display("FAIL play_entry got %h want %h", obs, ex(2,0,0,0,1,0)); else pass_cnt++;
  endtask
  task automatic test_score;
    pulse(0, 1, 0);
    total++; if (obs !== ex(3,1,0,2,0,0)) $display("FAIL p0_point got %h want %h", obs, ex(3,1,0,2,0,0)); else pass_cnt++;
    pulse(0, 0, 1);
    total++; if (obs !== ex(3,1,0,2,0,0)) $display("FAIL point_hit_ignored got %h want %h", obs, ex(3,1,0,2,0,0)); else pass_cnt++;
    cyc(3);
    total++; if (obs !== ex(3,1,0,1,0,0)) $display("FAIL point_tick1 got %h want %h", obs, ex(3,1,0,1,0,0)); else pass_cnt++;
    cyc(3);
    total++; if (obs !== ex(3,1,0,1,0,0)) $display("FAIL point_hold got %h want %h", obs, ex(3,1,0,1,0,0)); else pass_cnt++;
    cyc(1);
    total++; if (obs !== ex(1,1,0,3,0,0)) $display("FAIL point_to_cd got %h want %h", obs, ex(1,1,0,3,0,0)); else pass_cnt++;
    pulse(0, 1, 1);
    total++; if (obs !== ex(1,1,0,3,0,0)) $display("FAIL cd_hit_ignored got %h want %h", obs, ex(1,1,0,3,0,0)); else pass_cnt++;
    cyc(10);
    total++; if (obs !== ex(1,1,0,1,0,0)) $display("FAIL cd_last got %h want %h", obs, ex(1,1,0,1,0,0)); else pass_cnt++;
    cyc(1);
    total++; if (obs !== ex(2,1,0,0,1,0)) $display("FAIL replay_entry got %h want %h", obs, ex(2,1,0,0,1,0)); else pass_cnt++;
  endtask
  task automatic test_simultaneous;
    pulse(0, 1, 1);
    total++; if (obs !== ex(2,1,0,0,1,0)) $display("FAIL both_hits got %h want %h", obs, ex(2,1,0,0,1,0)); else pass_cnt++;
    pulse(0, 1, 1);
    cyc(3);
    total++; if (obs !== ex(2,1,0,0,1,0)) $display("FAIL both_hits_later got %h want %h", obs, ex(2,1,0,0,1,0)); else pass_cnt++;
  endtask
  task automatic test_reset_mid;
    pulse(0, 0, 1);
    total++; if (obs !== ex(3,1,1,2,0,0)) $display("FAIL p1_point got %h want %h", obs, ex(3,1,1,2,0,0)); else pass_cnt++;
    cyc(1);
    rst = 0; start = 1; p0_hit = 1;
    cyc(1);
    rst = 1; start = 0; p0_hit = 0;
    total++; if (obs !== ex(0,0,0,0,0,0)) $display("FAIL reset_mid got %h want %h", obs, ex(0,0,0,0,0,0)); else pass_cnt++;
    cyc(2);
    total++; if (obs !== ex(0,0,0,0,0,0)) $display("FAIL reset_mid_idle got %h want %h", obs, ex(0,0,0,0,0,0)); else pass_cnt++;
    pulse(1, 0, 0);
    total++; if (obs !== ex(1,0,0,3,0,0)) $display("FAIL restart got %h want %h", obs, ex(1,0,0,3,0,0)); else pass_cnt++;
    cyc(3);
    total++; if (obs !== ex(1,0,0,3,0,0)) $display("FAIL restart_pre_tick got %h want %h", obs, ex(1,0,0,3,0,0)); else pass_cnt++;
    cyc(1);
    total++; if (obs !== ex(1,0,0,2,0,0)) $display("FAIL restart_first_tick got %h want %h", obs, ex(1,0,0,2,0,0)); else pass_cnt++;
    cyc(8);
    total++; if (obs !== ex(2,0,0,0,1,0)) $display("FAIL restart_play got %h want %h", obs, ex(2,0,0,0,1,0)); else pass_cnt++;
  endtask
  task automatic test_game_over;
    pulse(0, 0, 1);
    total++; if (obs !== ex(3,0,1,2,0,0)) $display("FAIL go_point1 got %h want %h", obs, ex(3,0,1,2,0,0)); else pass_cnt++;
    cyc(8);
    total++; if (obs !== ex(1,0,1,3,0,0)) $display("FAIL go_cd got %h want %h", obs, ex(1,0,1,3,0,0)); else pass_cnt++;
    cyc(12);
    total++; if (obs !== ex(2,0,1,0,1,0)) $display("FAIL go_play got %h want %h", obs, ex(2,0,1,0,1,0)); else pass_cnt++;
    pulse(0, 0, 1);
    total++; if (obs !== ex(3,0,2,2,0,0)) $display("FAIL go_point2 got %h want %h", obs, ex(3,0,2,2,0,0)); else pass_cnt++;
    cyc(7);
    total++; if (obs !== ex(3,0,2,1,0,0)) $display("FAIL go_hold got %h want %h", obs, ex(3,0,2,1,0,0)); else pass_cnt++;
    cyc(1);
    total++; if (obs !== ex(4,0,2,0,0,1)) $display("FAIL go_over got %h want %h", obs, ex(4,0,2,0,0,1)); else pass_cnt++;
    pulse(0, 1, 0);
    cyc(6);
    total++; if (obs !== ex(4,0,2,0,0,1)) $display("FAIL go_over_held got %h want %h", obs, ex(4,0,2,0,0,1)); else pass_cnt++;
    pulse(1, 0, 0);
    total++; if (obs !== ex(1,0,0,3,0,1)) $display("FAIL go_restart got %h want %h", obs, ex(1,0,0,3,0,1)); else pass_cnt++;
  endtask
  task automatic test_illegal;
    force dut.state_q = game_pkg::state_t'(3'd6);
    #1;
    release dut.state_q;
    cyc(1);
    total++; if (obs !== ex(0,0,0,0,0,1)) $display("FAIL illegal_recover got %h want %h", obs, ex(0,0,0,0,0,1)); else pass_cnt++;
    cyc(2);
    total++; if (obs !== ex(0,0,0,0,0,1)) $display("FAIL illegal_idle got %h want %h", obs, ex(0,0,0,0,0,1)); else pass_cnt++;
  endtask
  // model: a game is a list of points; each point costs a countdown of CF*TD cycles and a hold of PH*TD cycles
  task automatic test_random;
    int s0 = 0, s1 = 0, w = 1, games = 0;
    pulse(1, 0, 0);
    total++; if (obs !== ex(1,0,0,CF,0,w)) $display("FAIL rnd_start got %h want %h", obs, ex(1,0,0,CF,0,w)); else pass_cnt++;
    while (games < 6) begin
      noise(CF * TD - 1, 1);
      total++; if (obs !== ex(1,s0,s1,1,0,w)) $display("FAIL rnd_cd_end got %h want %h", obs, ex(1,s0,s1,1,0,w)); else pass_cnt++;
      cyc(1);
      total++; if (obs !== ex(2,s0,s1,0,1,w)) $display("FAIL rnd_play got %h want %h", obs, ex(2,s0,s1,0,1,w)); else pass_cnt++;
      repeat ($urandom_range(0, 4)) begin
        if ($urandom_range(0, 1) == 1) pulse(1, 1, 1);
        else cyc(1);
      end
      total++; if (obs !== ex(2,s0,s1,0,1,w)) $display("FAIL rnd_play_idle got %h want %h", obs, ex(2,s0,s1,0,1,w)); else pass_cnt++;
      if ($urandom_range(0, 1) == 1) begin
        pulse(0, 0, 1);
        s1++;
      end else begin
        pulse(0, 1, 0);
        s0++;
      end
      total++; if (obs !== ex(3,s0,s1,PH,0,w)) $display("FAIL rnd_point got %h want %h", obs, ex(3,s0,s1,PH,0,w)); else pass_cnt++;
      noise(PH * TD - 1, 1);
      total++; if (obs !== ex(3,s0,s1,1,0,w)) $display("FAIL rnd_hold got %h want %h", obs, ex(3,s0,s1,1,0,w)); else pass_cnt++;
      cyc(1);
      if (s0 == WS || s1 == WS) begin
        w = (s0 == WS) ? 0 : 1;
        games++;
        total++; if (obs !== ex(4,s0,s1,0,0,w)) $display("FAIL rnd_over got %h want %h", obs, ex(4,s0,s1,0,0,w)); else pass_cnt++;
        noise($urandom_range(1, 6), 0);
        total++; if (obs !== ex(4,s0,s1,0,0,w)) $display("FAIL rnd_over_held got %h want %h", obs, ex(4,s0,s1,0,0,w)); else pass_cnt++;
        pulse(1, 0, 0);
        s0 = 0;
        s1 = 0;
      end
      total++; if (obs !== ex(1,s0,s1,CF,0,w)) $display("FAIL rnd_cd got %h want %h", obs, ex(1,s0,s1,CF,0,w)); else pass_cnt++;
    end
  endtask
  initial begin
    test_reset;
    test_start;
    test_score;
    test_simultaneous;
    test_reset_mid;
    test_game_over;
    test_illegal;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Game-flow sequencer that drives the VGA display path. Owns the game state machine, both player scores and the on-screen countdown digit. Its `state`, `score0`, `score1` and `cnt0` outputs feed the display top-level directly. It also gates the gameplay logic through `play_en`. All timing derives from an internal 1-second tick prescaler.

## Interface

Parameters:
- `TICK_DIV`, default 100_000_000: clk cycles per countdown tick (1 s at 100 MHz).
- `COUNT_FROM`, default 3: countdown start value, 1..15.
- `POINT_HOLD`, default 2: ticks the POINT state is held after a score, 1..15.
- `WIN_SCORE`, default 5: score that ends the game, 1..15.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: one-cycle pulse from the debounced start button.
- `p0_hit`, in, 1: one-cycle pulse; player 0 scored a point.
- `p1_hit`, in, 1: one-cycle pulse; player 1 scored a point.
- `state`, out, 3: current game state (encoding below).
- `score0`, out, 4: player 0 score.
- `score1`, out, 4: player 1 score.
- `cnt0`, out, 4: countdown/hold digit shown on screen.
- `play_en`, out, 1: high only in PLAY; enables ball/paddle logic.
- `winner`, out, 1: 0 = player 0 won, 1 = player 1 won; valid in OVER.

## Operation

State encodings: IDLE=0, COUNTDOWN=1, PLAY=2, POINT=3, OVER=4. Values 5–7 are illegal and recover to IDLE on the next cycle.

- **IDLE**: `score0` = `score1` = `cnt0` = 0.
  - `start` → COUNTDOWN; `cnt0` ← COUNT_FROM.
- **COUNTDOWN**: each tick decrements `cnt0`.
  - A tick while `cnt0`==1 → PLAY; `cnt0` ← 0.
  - `start` is ignored.
- **PLAY**: `play_en`=1.
  - `p0_hit` alone: `score0`+1 → POINT.
  - `p1_hit` alone: `score1`+1 → POINT.
  - Both in the same cycle: no score, remain in PLAY.
  - On entry to POINT, `cnt0` ← POINT_HOLD.
- **POINT**: each tick decrements `cnt0`. A tick while `cnt0`==1 resolves the point:
  - If `score0`==WIN_SCORE: → OVER, `winner` ← 0.
  - Else if `score1`==WIN_SCORE: → OVER, `winner` ← 1.
  - Else: → COUNTDOWN, `cnt0` ← COUNT_FROM.
  - Hits are ignored in POINT.
- **OVER**: scores and `winner` are held; `cnt0` = 0.
  - `start` → COUNTDOWN; scores cleared; `cnt0` ← COUNT_FROM; `winner` held until the next OVER.

Score and tick rules:
- Scores are 4-bit and saturate at 15. Saturation is unreachable when WIN_SCORE ≤ 15.
- Hits outside PLAY are dropped and are never queued.
- The tick prescaler counts 0..TICK_DIV-1 and asserts `tick` for one cycle at TICK_DIV-1.
- The prescaler is cleared to 0 on every state transition, so the first tick in any state lands exactly TICK_DIV cycles after entry.

## Timing

- All outputs are registered. An input sampled at edge N is reflected in outputs after edge N.
- The `start` → `state`=1 latency is 1 cycle.
- A hit in PLAY updates `state`=3 and the score in the same output update.
- The COUNTDOWN dwell is exactly COUNT_FROM×TICK_DIV cycles.
- The POINT dwell is exactly POINT_HOLD×TICK_DIV cycles.
- Reset values: `state`=0, `score0`=0, `score1`=0, `cnt0`=0, `play_en`=0, `winner`=0, prescaler=0.
- Reset asserted mid-game returns every output to its reset value on the next edge. An event input arriving in the same cycle as reset is ignored.
- `start` coinciding with a tick in COUNTDOWN has no effect beyond the tick.

## Structure

- Shared package `game_pkg`: state encodings (`ST_IDLE` … `ST_OVER`), 3-bit state type, 4-bit score type.
- The display pixel generator imports the same encodings.
- One sub-module, `tick_gen`:
  - Parameter TICK_DIV; counter width $clog2(TICK_DIV).
  - Inputs `clk`, `rst`, `clr`; output `tick`.
- The FSM, score registers and `cnt0` logic stay in `game_flow_ctrl`.

## Test plan

All scenarios use TICK_DIV=4, COUNT_FROM=3, POINT_HOLD=2, WIN_SCORE=2.

- **Reset and start**: release `rst`, pulse `start` at cycle 10.
  - `state`=1 and `cnt0`=3 at cycle 11.
  - `cnt0` reads 2 at cycle 15 and 1 at cycle 19.
  - `state`=2, `play_en`=1, `cnt0`=0 at cycle 23.
- **Score path**: pulse `p0_hit` in PLAY.
  - Next cycle: `score0`=1, `state`=3, `cnt0`=2, `play_en`=0.
  - After 8 cycles: `state`=1, `cnt0`=3.
- **Game over**: reach `score1`=2 by hits.
  - After the POINT hold: `state`=4, `winner`=1, scores 0/2 held.
  - `start` then gives `state`=1 with scores 0/0.
- **Simultaneous hits**: `p0_hit` and `p1_hit` together in PLAY.
  - `state` stays 2; scores unchanged.
  - Hits pulsed during COUNTDOWN and POINT are ignored.
- **Reset mid-operation**: assert `rst` low during POINT with `score0`=1.
  - Next edge: all outputs zero, `state`=0.
  - The first countdown tick after a new `start` arrives exactly 4 cycles later.
- **Illegal state**: force the state register to 6.
  - Next cycle `state`=0; outputs are as in IDLE.
